bt_tx_arbiter: RTL and testbench

Shares the single UART transmit channel to the RN41 Bluetooth module among several byte producers: the wireless request/response handler, telemetry streaming and debug output. It grants one requester at a time round-robin, issues the one-cycle `transmit` strobe with the granted byte, and tracks the UART's `is_transmitting` line until the byte is on the wire. It enforces an optional inter-byte gap, and recovers with an error pulse if the UART never starts.

---
 rtl/bt_tx_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_bt_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_tx_arbiter.sv
// bt_tx_arbiter
// Round-robin arbiter that shares the single UART transmit channel to the
// RN41 Bluetooth module among NUM_REQ byte producers. The arbiter grants one
// requester at a time and launches that byte with a one-cycle transmit
// strobe. It then follows the UART busy flag until the byte has left, and
// optionally inserts an idle gap before the next grant. If the UART never
// raises is_transmitting, the byte is dropped and tx_err pulses for one cycle.
// All outputs are registered.

module bt_tx_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_byte,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   transmit,
    output logic [7:0]             tx_byte,
    input  logic                   is_transmitting,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   tx_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LAUNCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    // The counter value at which the UART is declared dead.
    localparam logic [7:0] TMO_LIMIT = 8'(START_TIMEOUT);

    // GAP always lasts at least one cycle. With GAP_CYCLES = g > 0 it lasts
    // g cycles, so the exit happens when the counter reaches g-1.
    localparam logic [7:0] GAP_LAST  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    // Highest requester index. The pointer wraps to 0 after this index.
    localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Round-robin search starting at pointer p and wrapping modulo NUM_REQ.
    // Result is {found, index}. The loop runs from the farthest candidate to
    // the nearest, so the nearest asserted request is the last one written
    // and therefore wins.
    function automatic logic [3:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [2:0]         p
    );
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (r[idx]) begin
                res = {1'b1, 3'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot vector with bit i set (i < NUM_REQ).
    function automatic logic [NUM_REQ-1:0] one_hot(input logic [2:0] i);
        logic [NUM_REQ-1:0] oh;
        for (int j = 0; j < NUM_REQ; j++) begin
            oh[j] = (3'(j) == i);
        end
        return oh;
    endfunction

    // Pointer value after a grant to index i.
    function automatic logic [2:0] next_ptr(input logic [2:0] i);
        logic [2:0] n;
        if (i >= LAST_IDX) begin
            n = 3'd0;
        end else begin
            n = i + 3'd1;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [2:0]         state_r,    state_s;
    logic [2:0]         ptr_r,      ptr_s;
    logic [7:0]         tx_byte_r,  tx_byte_s;
    logic [2:0]         grant_id_r, grant_id_s;
    logic [NUM_REQ-1:0] ack_r,      ack_s;
    logic               transmit_r, transmit_s;
    logic               tx_err_r,   tx_err_s;
    logic               busy_r,     busy_s;
    logic [7:0]         tmo_cnt_r,  tmo_cnt_s;
    logic [7:0]         gap_cnt_r,  gap_cnt_s;

    // Arbitration result for the current cycle. It is only used in IDLE.
    logic [3:0]         pick_s;
    logic               found_s;
    logic [2:0]         win_s;
    logic [7:0]         win_byte_s;
    logic [7:0]         tmo_inc_s;

    assign pick_s     = rr_pick(req, ptr_r);
    assign found_s    = pick_s[3];
    assign win_s      = pick_s[2:0];
    assign win_byte_s = req_byte[8*int'(win_s) +: 8];
    assign tmo_inc_s  = tmo_cnt_r + 8'd1;

    // Next-state logic. Registered outputs are computed one cycle ahead, so a
    // grant in IDLE raises transmit and ack during the LAUNCH cycle.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        tx_byte_s  = tx_byte_r;
        grant_id_s = grant_id_r;
        ack_s      = {NUM_REQ{1'b0}};
        transmit_s = 1'b0;
        tx_err_s   = 1'b0;
        tmo_cnt_s  = tmo_cnt_r;
        gap_cnt_s  = gap_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    // Latch the winner's byte now. Later req_byte changes do not affect it.
                    state_s    = ST_LAUNCH;
                    tx_byte_s  = win_byte_s;
                    grant_id_s = win_s;
                    ptr_s      = next_ptr(win_s);
                    ack_s      = one_hot(win_s);
                    transmit_s = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_LAUNCH: begin
                // Strobe and ack are high in this cycle. Arm the start timeout.
                tmo_cnt_s = 8'd0;
                state_s   = ST_WAIT_START;
            end

            ST_WAIT_START: begin
                if (is_transmitting) begin
                    state_s = ST_WAIT_DONE;
                end else begin
                    tmo_cnt_s = tmo_inc_s;
                    if (tmo_inc_s == TMO_LIMIT) begin
                        // UART never started. Drop the byte; the requester was already acked.
                        tx_err_s  = 1'b1;
                        gap_cnt_s = 8'd0;
                        state_s   = ST_GAP;
                    end else begin
                        state_s   = ST_WAIT_START;
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (!is_transmitting) begin
                    gap_cnt_s = 8'd0;
                    state_s   = ST_GAP;
                end else begin
                    state_s   = ST_WAIT_DONE;
                end
            end

            ST_GAP: begin
                if (gap_cnt_r >= GAP_LAST) begin
                    gap_cnt_s = 8'd0;
                    state_s   = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 8'd1;
                    state_s   = ST_GAP;
                end
            end

            default: begin
                // Unreachable encodings recover to a clean idle.
                state_s   = ST_IDLE;
                tmo_cnt_s = 8'd0;
                gap_cnt_s = 8'd0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers, with synchronous reset to the idle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 3'd0;
            tx_byte_r  <= 8'd0;
            grant_id_r <= 3'd0;
            ack_r      <= {NUM_REQ{1'b0}};
            transmit_r <= 1'b0;
            tx_err_r   <= 1'b0;
            busy_r     <= 1'b0;
            tmo_cnt_r  <= 8'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            tx_byte_r  <= tx_byte_s;
            grant_id_r <= grant_id_s;
            ack_r      <= ack_s;
            transmit_r <= transmit_s;
            tx_err_r   <= tx_err_s;
            busy_r     <= busy_s;
            tmo_cnt_r  <= tmo_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
        end
    end

    assign ack      = ack_r;
    assign transmit = transmit_r;
    assign tx_byte  = tx_byte_r;
    assign busy     = busy_r;
    assign grant_id = grant_id_r;
    assign tx_err   = tx_err_r;

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Testbench for bt_tx_arbiter. It uses two instances: one with the default
// gap and one with GAP_CYCLES=5. Each instance has a small behavioural UART
// model. Round-robin behaviour is checked from a table of vectors, and the
// multi-cycle corner cases are checked with hand-written sequences.

module tb_bt_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    // Main instance (GAP_CYCLES = 0)
    logic [2:0]  req;
    logic [23:0] req_byte;
    logic [2:0]  ack;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_tx;
    logic        busy;
    logic [2:0]  grant_id;
    logic        tx_err;

    // Gap instance (GAP_CYCLES = 5)
    logic [2:0]  req_g;
    logic [23:0] req_byte_g;
    logic [2:0]  ack_g;
    logic        transmit_g;
    logic [7:0]  tx_byte_g;
    logic        is_tx_g;
    logic        busy_g;
    logic [2:0]  grant_id_g;
    logic        tx_err_g;

    // UART model controls
    int          uart_len = 10;
    bit          uart_on  = 1'b1;
    int          uart_len_g = 3;

    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] bytes;
        logic [2:0]  gid;
        logic [2:0]  ack;
        logic [7:0]  txb;
    } vec_t;

    vec_t vecs [9];

    bt_tx_arbiter #(.NUM_REQ(3), .START_TIMEOUT(16), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req(req), .req_byte(req_byte), .ack(ack),
        .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_tx),
        .busy(busy), .grant_id(grant_id), .tx_err(tx_err)
    );

    bt_tx_arbiter #(.NUM_REQ(3), .START_TIMEOUT(16), .GAP_CYCLES(5)) dut_g (
        .clk(clk), .rst(rst), .req(req_g), .req_byte(req_byte_g), .ack(ack_g),
        .transmit(transmit_g), .tx_byte(tx_byte_g), .is_transmitting(is_tx_g),
        .busy(busy_g), .grant_id(grant_id_g), .tx_err(tx_err_g)
    );

    always #5 clk = ~clk;

    // UART model: goes busy one cycle after a strobe, for uart_len cycles.
    // It updates 3 time units after the rising edge, so the bench samples a
    // stable value at the falling edge.
    initial begin : uart_main
        int pend;
        int cnt;
        pend  = 0;
        cnt   = 0;
        is_tx = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) is_tx = 1'b0;
            end
            if (pend != 0) begin
                pend  = 0;
                is_tx = 1'b1;
                cnt   = uart_len;
            end
            if (transmit && uart_on) pend = 1;
        end
    end

    // UART model for the gap instance (same behaviour, own length).
    initial begin : uart_gap
        int pend;
        int cnt;
        pend    = 0;
        cnt     = 0;
        is_tx_g = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) is_tx_g = 1'b0;
            end
            if (pend != 0) begin
                pend    = 0;
                is_tx_g = 1'b1;
                cnt     = uart_len_g;
            end
            if (transmit_g) pend = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the main instance to return to IDLE.
    task automatic wait_idle(input string name, input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int k;
        int fall;
        int n;
        bit seen_hi;
        logic [7:0] got_b [4];
        logic [2:0] got_g [4];
        logic [2:0] got_a [4];
        logic [7:0] exp_b [4];
        logic [2:0] exp_g [4];
        logic [2:0] exp_a [4];

        // Round-robin vectors. The pointer carries over from the fairness sequence (pointer=1).
        vecs[0] = '{3'b100, 24'hC3B2A1, 3'd2, 3'b100, 8'hC3};
        vecs[1] = '{3'b110, 24'h030201, 3'd1, 3'b010, 8'h02};
        vecs[2] = '{3'b110, 24'hFF0080, 3'd2, 3'b100, 8'hFF};
        vecs[3] = '{3'b011, 24'h123456, 3'd0, 3'b001, 8'h56};
        vecs[4] = '{3'b101, 24'h9ABCDE, 3'd2, 3'b100, 8'h9A};
        vecs[5] = '{3'b010, 24'h007E00, 3'd1, 3'b010, 8'h7E};
        vecs[6] = '{3'b001, 24'hAABBCC, 3'd0, 3'b001, 8'hCC};
        vecs[7] = '{3'b111, 24'h445566, 3'd1, 3'b010, 8'h55};
        vecs[8] = '{3'b011, 24'h778899, 3'd0, 3'b001, 8'h99};

        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h11;
        exp_g[0] = 3'd0;  exp_g[1] = 3'd1;  exp_g[2] = 3'd2;  exp_g[3] = 3'd0;
        exp_a[0] = 3'b001; exp_a[1] = 3'b010; exp_a[2] = 3'b100; exp_a[3] = 3'b001;

        rst = 1'b1;
        req = 3'b000; req_byte = 24'h0;
        req_g = 3'b000; req_byte_g = 24'h0;
        repeat (3) @(negedge clk);

        // ---------------- reset values ----------------
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_tx_byte",  32'(tx_byte),  32'd0);
        check("rst_ack",      32'(ack),      32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_tx_err",   32'(tx_err),   32'd0);
        check("rst_g_busy",   32'(busy_g),   32'd0);
        rst = 1'b0;

        // ---------------- single request ----------------
        @(negedge clk);
        req = 3'b001; req_byte = 24'h00005A;
        @(negedge clk);
        check("single_transmit", 32'(transmit), 32'd1);
        check("single_ack",      32'(ack),      32'b001);
        check("single_tx_byte",  32'(tx_byte),  32'h5A);
        check("single_grant",    32'(grant_id), 32'd0);
        check("single_busy",     32'(busy),     32'd1);
        req = 3'b000; req_byte = 24'h0;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("single_strobe_width", 32'(transmit), 32'd0);
                check("single_ack_width",    32'(ack),      32'd0);
            end
            if (!busy) begin
                k = c;
                break;
            end
        end
        // LAUNCH, 1 WAIT_START, 10 WAIT_DONE, 1 GAP -> IDLE on cycle 13
        check("single_busy_drop", 32'(k), 32'd13);
        check("single_byte_hold", 32'(tx_byte), 32'h5A);

        // ---------------- fairness ----------------
        pulse_reset();
        uart_len = 2;
        req = 3'b111; req_byte = 24'h332211;
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clk);
            if (transmit) begin
                got_b[n] = tx_byte;
                got_g[n] = grant_id;
                got_a[n] = ack;
                n++;
                if (n == 4) req = 3'b000;
            end
        end
        check("fair_launches", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            check($sformatf("fair_byte_%0d", i),  32'(got_b[i]), 32'(exp_b[i]));
            check($sformatf("fair_grant_%0d", i), 32'(got_g[i]), 32'(exp_g[i]));
            check($sformatf("fair_ack_%0d", i),   32'(got_a[i]), 32'(exp_a[i]));
        end
        wait_idle("fair_idle", 50);

        // ---------------- table-driven round robin ----------------
        uart_len = 3;
        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req; req_byte = vecs[i].bytes;
            @(negedge clk);
            check($sformatf("vec%0d_transmit", i), 32'(transmit), 32'd1);
            check($sformatf("vec%0d_ack", i),      32'(ack),      32'(vecs[i].ack));
            check($sformatf("vec%0d_grant", i),    32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("vec%0d_tx_byte", i),  32'(tx_byte),  32'(vecs[i].txb));
            req = 3'b000; req_byte = 24'h0;
            wait_idle($sformatf("vec%0d_idle", i), 50);
            check($sformatf("vec%0d_byte_hold", i), 32'(tx_byte), 32'(vecs[i].txb));
        end

        // ---------------- start timeout ----------------
        uart_on = 1'b0;
        req = 3'b001; req_byte = 24'h0000E7;
        @(negedge clk);
        check("tmo_ack", 32'(ack), 32'b001);
        req = 3'b100; req_byte = 24'h4D0000;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5) uart_on = 1'b1;
            if (tx_err) begin
                k = c;
                break;
            end
        end
        // WAIT_START entered on cycle 1; 16 cycles later the error pulses
        check("tmo_err_cycle", 32'(k), 32'd17);
        check("tmo_err_no_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("tmo_err_width", 32'(tx_err), 32'd0);
        check("tmo_idle",      32'(busy),   32'd0);
        @(negedge clk);
        check("tmo_next_transmit", 32'(transmit), 32'd1);
        check("tmo_next_ack",      32'(ack),      32'b100);
        check("tmo_next_byte",     32'(tx_byte),  32'h4D);
        req = 3'b000; req_byte = 24'h0;
        wait_idle("tmo_next_idle", 50);

        // ---------------- gap (GAP_CYCLES=5 instance) ----------------
        req_g = 3'b011; req_byte_g = 24'h00BEEF;
        @(negedge clk);
        check("gap_first_transmit", 32'(transmit_g), 32'd1);
        check("gap_first_byte",     32'(tx_byte_g),  32'hEF);
        req_g = 3'b010;
        k = 0; fall = 0; seen_hi = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (is_tx_g) seen_hi = 1'b1;
            if (seen_hi && !is_tx_g && fall == 0) fall = c;
            if (transmit_g) begin
                k = c;
                break;
            end
        end
        check("gap_uart_fall", 32'(fall), 32'd4);
        // falls during cycle 4, 5 GAP cycles, 1 IDLE, strobe on cycle 11
        check("gap_second_transmit", 32'(k - fall), 32'd7);
        check("gap_second_ack",      32'(ack_g),    32'b010);
        check("gap_second_byte",     32'(tx_byte_g), 32'hBE);
        req_g = 3'b000;
        for (int c = 0; c < 50 && busy_g; c++) @(negedge clk);
        check("gap_idle", 32'(busy_g), 32'd0);

        // ---------------- reset mid-operation ----------------
        req = 3'b001; req_byte = 24'h000001;
        @(negedge clk);
        check("pre_rst_ack", 32'(ack), 32'b001);
        req = 3'b000;
        wait_idle("pre_rst_idle", 50);
        uart_len = 10;
        req = 3'b111; req_byte = 24'hC0B0A0;
        @(negedge clk);
        check("mid_grant", 32'(grant_id), 32'd1);
        req = 3'b000;
        repeat (4) @(negedge clk);
        check("mid_in_wait_done", 32'(busy & is_tx), 32'd1);
        rst = 1'b1; req = 3'b111;
        @(negedge clk);
        check("mid_rst_transmit", 32'(transmit), 32'd0);
        check("mid_rst_tx_byte",  32'(tx_byte),  32'd0);
        check("mid_rst_ack",      32'(ack),      32'd0);
        check("mid_rst_busy",     32'(busy),     32'd0);
        check("mid_rst_grant",    32'(grant_id), 32'd0);
        check("mid_rst_tx_err",   32'(tx_err),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_transmit", 32'(transmit), 32'd1);
        check("post_rst_ack",      32'(ack),      32'b001);
        check("post_rst_grant",    32'(grant_id), 32'd0);
        check("post_rst_byte",     32'(tx_byte),  32'hA0);
        req = 3'b000;
        wait_idle("post_rst_idle", 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
